// File: rtl/decode_stage_pkg.sv
// Shared RV32I encodings, ALU op codes and the decoded-instruction record
// that the decode stage registers toward execute.
package decode_stage_pkg;

    localparam int ALU_OP_WIDTH = 4;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [ALU_OP_WIDTH-1:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
        ALU_OR,  ALU_AND, ALU_EQ,  ALU_NE,  ALU_LT,   ALU_GE,  ALU_LTU, ALU_GEU
    } alu_op_e;

    typedef struct packed {
        alu_op_e     alu_op;
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [4:0]  rd_addr;
        logic        rd_we;
        logic        is_load;
        logic        is_store;
        logic        is_branch;
        logic        is_jump;
        logic        mem_signed;
        logic        compressed;
        logic        illegal;
        logic [1:0]  mem_size;
    } dec_t;

    function automatic logic [31:0] imm_i(input logic [31:0] ir);
        return {{20{ir[31]}}, ir[31:20]};
    endfunction

    function automatic logic [31:0] imm_s(input logic [31:0] ir);
        return {{20{ir[31]}}, ir[31:25], ir[11:7]};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] ir);
        return {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_u(input logic [31:0] ir);
        return {ir[31:12], 12'b0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] ir);
        return {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
    endfunction

    function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/decode_stage_register_file.sv
// 31x32 integer register file: two async read ports with writeback bypass,
// one sync write port; x0 is hardwired to zero and has no storage.
module register_file (
    input  logic        clk,
    input  logic [4:0]  raddr_a_i,
    output logic [31:0] rdata_a_o,
    input  logic [4:0]  raddr_b_i,
    output logic [31:0] rdata_b_o,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i
);

    logic [31:0] mem_q [1:31];

    always_ff @(posedge clk) begin
        if (we_i && waddr_i != 5'd0) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata_a_o = '0;
        if (raddr_a_i != 5'd0) begin
            rdata_a_o = (we_i && waddr_i == raddr_a_i) ? wdata_i : mem_q[raddr_a_i];
        end
    end

    always_comb begin
        rdata_b_o = '0;
        if (raddr_b_i != 5'd0) begin
            rdata_b_o = (we_i && waddr_i == raddr_b_i) ? wdata_i : mem_q[raddr_b_i];
        end
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode: register read, scoreboard hazard check, registered issue to execute.
// Latency: 1 cycle issue -> ex_valid_o; 1 instr/cycle without hazards.
// Backpressure: output register holds while ex_ready_i=0; retire_inst_o drops on stall/hazard/flush.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDRESS = 32'h0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [31:0]             instr_i,
    input  logic [31:0]             instr_addr_i,
    input  logic                    instr_valid_i,
    input  logic                    compressed_inst_i,
    input  logic                    illegal_compressed_inst_i,
    output logic                    retire_inst_o,
    input  logic                    flush_i,
    output logic                    ex_valid_o,
    input  logic                    ex_ready_i,
    output logic [ALU_OP_WIDTH-1:0] alu_op_o,
    output logic [31:0]             operand_a_o,
    output logic [31:0]             operand_b_o,
    output logic [31:0]             rs2_data_o,
    output logic [31:0]             imm_o,
    output logic [31:0]             pc_o,
    output logic [4:0]              rd_addr_o,
    output logic                    rd_we_o,
    output logic                    is_load_o,
    output logic                    is_store_o,
    output logic                    is_branch_o,
    output logic                    is_jump_o,
    output logic                    mem_signed_o,
    output logic [1:0]              mem_size_o,
    output logic                    compressed_o,
    output logic                    illegal_inst_o,
    input  logic                    wb_we_i,
    input  logic [4:0]              wb_addr_i,
    input  logic [31:0]             wb_data_i
);

    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data, link;
    logic        use_rs1, use_rs2, known, hazard, issue;
    dec_t        dec, out_q, out_d;
    logic        ex_valid_q, ex_valid_d;
    logic [31:0] busy_q, busy_d, busy_set, busy_clr;

    assign opcode   = instr_i[6:0];
    assign funct3   = instr_i[14:12];
    assign funct7   = instr_i[31:25];
    assign rs1_addr = instr_i[19:15];
    assign rs2_addr = instr_i[24:20];
    assign link     = compressed_inst_i ? 32'd2 : 32'd4;

    register_file u_rf (
        .clk       (clk),
        .raddr_a_i (rs1_addr),
        .rdata_a_o (rs1_data),
        .raddr_b_i (rs2_addr),
        .rdata_b_o (rs2_data),
        .we_i      (wb_we_i),
        .waddr_i   (wb_addr_i),
        .wdata_i   (wb_data_i)
    );

    always_comb begin
        dec            = '0;
        dec.alu_op     = ALU_ADD;
        dec.pc         = instr_addr_i;
        dec.rd_addr    = instr_i[11:7];
        dec.compressed = compressed_inst_i;
        dec.rs2_data   = rs2_data;
        use_rs1        = 1'b0;
        use_rs2        = 1'b0;
        known          = 1'b1;
        case (opcode)
            OPC_LUI: begin
                dec.op_b = imm_u(instr_i); dec.imm = imm_u(instr_i); dec.rd_we = 1'b1;
            end
            OPC_AUIPC: begin
                dec.op_a = instr_addr_i; dec.op_b = imm_u(instr_i);
                dec.imm = imm_u(instr_i); dec.rd_we = 1'b1;
            end
            OPC_JAL: begin
                dec.op_a = instr_addr_i; dec.op_b = link; dec.imm = imm_j(instr_i);
                dec.is_jump = 1'b1; dec.rd_we = 1'b1;
            end
            OPC_JALR: begin
                // Execute forms the target from rs2_data_o (rs1 here) + imm.
                known = (funct3 == 3'b000); use_rs1 = 1'b1;
                dec.op_a = instr_addr_i; dec.op_b = link; dec.imm = imm_i(instr_i);
                dec.rs2_data = rs1_data; dec.is_jump = 1'b1; dec.rd_we = 1'b1;
            end
            OPC_BRANCH: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1;
                dec.op_a = rs1_data; dec.op_b = rs2_data; dec.imm = imm_b(instr_i);
                dec.is_branch = 1'b1;
                case (funct3)
                    3'b000:  dec.alu_op = ALU_EQ;
                    3'b001:  dec.alu_op = ALU_NE;
                    3'b100:  dec.alu_op = ALU_LT;
                    3'b101:  dec.alu_op = ALU_GE;
                    3'b110:  dec.alu_op = ALU_LTU;
                    3'b111:  dec.alu_op = ALU_GEU;
                    default: known = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                known = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
                use_rs1 = 1'b1;
                dec.op_a = rs1_data; dec.op_b = imm_i(instr_i); dec.imm = imm_i(instr_i);
                dec.is_load = 1'b1; dec.rd_we = 1'b1;
                dec.mem_size = funct3[1:0]; dec.mem_signed = ~funct3[2];
            end
            OPC_STORE: begin
                known = !funct3[2] && (funct3[1:0] != 2'b11);
                use_rs1 = 1'b1; use_rs2 = 1'b1;
                dec.op_a = rs1_data; dec.op_b = imm_s(instr_i); dec.imm = imm_s(instr_i);
                dec.is_store = 1'b1; dec.mem_size = funct3[1:0];
            end
            OPC_OPIMM: begin
                known = (funct3 != 3'b001 && funct3 != 3'b101) || funct7 == F7_ZERO ||
                        (funct3 == 3'b101 && funct7 == F7_ALT);
                use_rs1 = 1'b1;
                dec.op_a = rs1_data; dec.op_b = imm_i(instr_i); dec.imm = imm_i(instr_i);
                dec.alu_op = alu_from_f3(funct3, funct3 == 3'b101 && funct7[5]);
                dec.rd_we = 1'b1;
            end
            OPC_OP: begin
                known = funct7 == F7_ZERO ||
                        (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101));
                use_rs1 = 1'b1; use_rs2 = 1'b1;
                dec.op_a = rs1_data; dec.op_b = rs2_data;
                dec.alu_op = alu_from_f3(funct3, funct7[5]);
                dec.rd_we = 1'b1;
            end
            OPC_FENCE, OPC_SYSTEM: ;
            default: known = 1'b0;
        endcase
        if (!known || illegal_compressed_inst_i) begin
            dec.illegal   = 1'b1;
            dec.rd_we     = 1'b0;
            dec.is_load   = 1'b0;
            dec.is_store  = 1'b0;
            dec.is_branch = 1'b0;
            dec.is_jump   = 1'b0;
            use_rs1       = 1'b0;
            use_rs2       = 1'b0;
        end
        if (dec.rd_addr == 5'd0) dec.rd_we = 1'b0;
    end

    // A busy bit being released by this cycle's writeback is already safe thanks to the bypass.
    always_comb begin
        hazard = 1'b0;
        if (use_rs1 && rs1_addr != 5'd0 &&
            ((busy_q[rs1_addr] && !(wb_we_i && wb_addr_i == rs1_addr)) ||
             (ex_valid_q && out_q.rd_we && out_q.rd_addr == rs1_addr))) hazard = 1'b1;
        if (use_rs2 && rs2_addr != 5'd0 &&
            ((busy_q[rs2_addr] && !(wb_we_i && wb_addr_i == rs2_addr)) ||
             (ex_valid_q && out_q.rd_we && out_q.rd_addr == rs2_addr))) hazard = 1'b1;
    end

    assign issue         = instr_valid_i && !flush_i && !hazard && (!ex_valid_q || ex_ready_i);
    assign retire_inst_o = issue;

    always_comb begin
        out_d      = out_q;
        ex_valid_d = ex_valid_q;
        if (issue) begin
            out_d      = dec;
            ex_valid_d = 1'b1;
        end else if (ex_ready_i || flush_i) begin
            ex_valid_d = 1'b0;
        end
        busy_set = '0;
        busy_clr = '0;
        if (ex_valid_q && ex_ready_i && out_q.rd_we && !flush_i) busy_set[out_q.rd_addr] = 1'b1;
        if (wb_we_i) busy_clr[wb_addr_i] = 1'b1;
        busy_d    = (busy_q | busy_set) & ~busy_clr;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q      <= '0;
            out_q.pc   <= BOOT_ADDRESS;
            ex_valid_q <= 1'b0;
            busy_q     <= '0;
        end else begin
            out_q      <= out_d;
            ex_valid_q <= ex_valid_d;
            busy_q     <= busy_d;
        end
    end

    assign ex_valid_o     = ex_valid_q;
    assign alu_op_o       = out_q.alu_op;
    assign operand_a_o    = out_q.op_a;
    assign operand_b_o    = out_q.op_b;
    assign rs2_data_o     = out_q.rs2_data;
    assign imm_o          = out_q.imm;
    assign pc_o           = out_q.pc;
    assign rd_addr_o      = out_q.rd_addr;
    assign rd_we_o        = out_q.rd_we;
    assign is_load_o      = out_q.is_load;
    assign is_store_o     = out_q.is_store;
    assign is_branch_o    = out_q.is_branch;
    assign is_jump_o      = out_q.is_jump;
    assign mem_signed_o   = out_q.mem_signed;
    assign mem_size_o     = out_q.mem_size;
    assign compressed_o   = out_q.compressed;
    assign illegal_inst_o = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage with hand-encoded RV32I instructions.
module tb_decode_stage;
    import decode_stage_pkg::*;

    localparam logic [31:0] BOOT = 32'h8000_0000;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [31:0]             instr_i, instr_addr_i;
    logic                    instr_valid_i, compressed_inst_i, illegal_compressed_inst_i;
    logic                    retire_inst_o, flush_i, ex_valid_o, ex_ready_i;
    logic [ALU_OP_WIDTH-1:0] alu_op_o;
    logic [31:0]             operand_a_o, operand_b_o, rs2_data_o, imm_o, pc_o;
    logic [4:0]              rd_addr_o;
    logic                    rd_we_o, is_load_o, is_store_o, is_branch_o, is_jump_o;
    logic                    mem_signed_o, compressed_o, illegal_inst_o;
    logic [1:0]              mem_size_o;
    logic                    wb_we_i;
    logic [4:0]              wb_addr_i;
    logic [31:0]             wb_data_i;

    int n_chk = 0;
    int n_err = 0;

    decode_stage #(.BOOT_ADDRESS(BOOT)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_i(instr_i), .instr_addr_i(instr_addr_i), .instr_valid_i(instr_valid_i),
        .compressed_inst_i(compressed_inst_i),
        .illegal_compressed_inst_i(illegal_compressed_inst_i),
        .retire_inst_o(retire_inst_o), .flush_i(flush_i),
        .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i), .alu_op_o(alu_op_o),
        .operand_a_o(operand_a_o), .operand_b_o(operand_b_o), .rs2_data_o(rs2_data_o),
        .imm_o(imm_o), .pc_o(pc_o), .rd_addr_o(rd_addr_o), .rd_we_o(rd_we_o),
        .is_load_o(is_load_o), .is_store_o(is_store_o), .is_branch_o(is_branch_o),
        .is_jump_o(is_jump_o), .mem_signed_o(mem_signed_o), .mem_size_o(mem_size_o),
        .compressed_o(compressed_o), .illegal_inst_o(illegal_inst_o),
        .wb_we_i(wb_we_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ir, input logic [31:0] pc,
                         input logic c, input logic ic);
        instr_valid_i             = v;
        instr_i                   = ir;
        instr_addr_i              = pc;
        compressed_inst_i         = c;
        illegal_compressed_inst_i = ic;
    endtask

    task automatic wb(input logic we, input logic [4:0] a, input logic [31:0] d);
        wb_we_i   = we;
        wb_addr_i = a;
        wb_data_i = d;
    endtask

    initial begin
        rst_n      = 1'b0;
        flush_i    = 1'b0;
        ex_ready_i = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        wb(1'b0, 5'd0, 32'h0);
        #12;
        chk("rst ex_valid", ex_valid_o, 0);
        chk("rst pc", pc_o, BOOT);
        chk("rst rd_we", rd_we_o, 0);
        chk("rst op_a", operand_a_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // ADDI x1,x0,5
        drive(1'b1, 32'h00500093, 32'h0, 1'b0, 1'b0);
        #1 chk("addi retire", retire_inst_o, 1);
        tick();
        chk("addi ex_valid", ex_valid_o, 1);
        chk("addi op_a", operand_a_o, 0);
        chk("addi op_b", operand_b_o, 5);
        chk("addi rd", rd_addr_o, 1);
        chk("addi rd_we", rd_we_o, 1);
        chk("addi alu", alu_op_o, ALU_ADD);

        // LW x2,0(x0); writeback x1 in the cycle its busy bit would be set
        drive(1'b1, 32'h00002103, 32'h4, 1'b0, 1'b0);
        wb(1'b1, 5'd1, 32'h11);
        #1 chk("lw retire", retire_inst_o, 1);
        tick();
        wb(1'b0, 5'd0, 32'h0);
        chk("lw is_load", is_load_o, 1);
        chk("lw size", mem_size_o, 2);
        chk("lw signed", mem_signed_o, 1);

        // ADD x3,x2,x2 waits for x2 writeback
        drive(1'b1, 32'h002101B3, 32'h8, 1'b0, 1'b0);
        #1 chk("raw stall ex", retire_inst_o, 0);
        tick();
        chk("raw bubble", ex_valid_o, 0);
        chk("raw stall busy", retire_inst_o, 0);
        tick();
        chk("raw stall busy2", retire_inst_o, 0);
        wb(1'b1, 5'd2, 32'h1234);
        #1 chk("raw wb issue", retire_inst_o, 1);
        tick();
        wb(1'b0, 5'd0, 32'h0);
        ex_ready_i = 1'b0;
        chk("raw op_a bypass", operand_a_o, 32'h1234);
        chk("raw op_b bypass", operand_b_o, 32'h1234);
        chk("raw rd", rd_addr_o, 3);

        // Backpressure: LUI x8,0xABCDE pending for 3 cycles
        drive(1'b1, 32'hABCDE437, 32'h40, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1 chk("bp retire", retire_inst_o, 0);
            tick();
            chk("bp ex_valid", ex_valid_o, 1);
            chk("bp hold op_a", operand_a_o, 32'h1234);
        end
        ex_ready_i = 1'b1;
        #1 chk("bp release retire", retire_inst_o, 1);
        tick();
        chk("lui op_a", operand_a_o, 0);
        chk("lui op_b", operand_b_o, 32'hABCDE000);
        chk("lui pc", pc_o, 32'h40);

        // ADDI x4,x0,7 then flush while it is held
        drive(1'b1, 32'h00700213, 32'h44, 1'b0, 1'b0);
        #1 chk("addi x4 retire", retire_inst_o, 1);
        tick();
        chk("addi x4 rd", rd_addr_o, 4);
        drive(1'b1, 32'h00120293, 32'h48, 1'b0, 1'b0);
        flush_i = 1'b1;
        #1 chk("flush retire", retire_inst_o, 0);
        tick();
        flush_i = 1'b0;
        chk("flush ex_valid", ex_valid_o, 0);
        #1 chk("x4 not busy", retire_inst_o, 1);
        tick();
        chk("addi x5 rd", rd_addr_o, 5);
        chk("addi x5 ex_valid", ex_valid_o, 1);

        // Compressed JAL x1 at 0x100
        drive(1'b1, 32'h000000EF, 32'h100, 1'b1, 1'b0);
        #1 chk("jal retire", retire_inst_o, 1);
        tick();
        chk("jal op_a", operand_a_o, 32'h100);
        chk("jal op_b", operand_b_o, 2);
        chk("jal is_jump", is_jump_o, 1);
        chk("jal rd_we", rd_we_o, 1);
        chk("jal compressed", compressed_o, 1);
        // Illegal compressed; x1 writeback collides with the JAL busy set
        drive(1'b1, 32'h000000EF, 32'h104, 1'b1, 1'b1);
        wb(1'b1, 5'd1, 32'h22);
        tick();
        wb(1'b0, 5'd0, 32'h0);
        chk("illc illegal", illegal_inst_o, 1);
        chk("illc rd_we", rd_we_o, 0);

        // ADD x0,x1,x1
        drive(1'b1, 32'h00108033, 32'h108, 1'b0, 1'b0);
        #1 chk("x1 clear wins", retire_inst_o, 1);
        tick();
        chk("add x0 rd_we", rd_we_o, 0);
        chk("add x0 op_a", operand_a_o, 32'h22);
        // ADD x6,x0,x0 with a writeback aimed at x0
        drive(1'b1, 32'h00000333, 32'h10C, 1'b0, 1'b0);
        wb(1'b1, 5'd0, 32'hDEAD);
        #1 chk("x0 read retire", retire_inst_o, 1);
        tick();
        wb(1'b0, 5'd0, 32'h0);
        chk("x0 op_a", operand_a_o, 0);
        chk("x0 op_b", operand_b_o, 0);

        // Back-to-back: SW x2,-4(x1); BEQ x0,x0,-8; unknown opcode
        drive(1'b1, 32'hFE20AE23, 32'h110, 1'b0, 1'b0);
        #1 chk("sw retire", retire_inst_o, 1);
        tick();
        chk("sw imm", imm_o, 32'hFFFFFFFC);
        chk("sw is_store", is_store_o, 1);
        chk("sw rd_we", rd_we_o, 0);
        chk("sw op_a", operand_a_o, 32'h22);
        chk("sw rs2_data", rs2_data_o, 32'h1234);
        drive(1'b1, 32'hFE000CE3, 32'h114, 1'b0, 1'b0);
        #1 chk("beq retire", retire_inst_o, 1);
        tick();
        chk("beq imm", imm_o, 32'hFFFFFFF8);
        chk("beq is_branch", is_branch_o, 1);
        chk("beq alu", alu_op_o, ALU_EQ);
        drive(1'b1, 32'hFFFFFFFF, 32'h118, 1'b0, 1'b0);
        #1 chk("unk retire", retire_inst_o, 1);
        tick();
        chk("unk illegal", illegal_inst_o, 1);
        chk("unk rd_we", rd_we_o, 0);
        chk("unk is_load", is_load_o, 0);

        // ADDI x7,x5,1 blocked by busy x5; reset mid-handshake clears it
        drive(1'b1, 32'h00128393, 32'h11C, 1'b0, 1'b0);
        #1 chk("x5 busy", retire_inst_o, 0);
        rst_n = 1'b0;
        #1;
        chk("mid rst ex_valid", ex_valid_o, 0);
        chk("mid rst pc", pc_o, BOOT);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("post rst busy clear", retire_inst_o, 1);
        tick();
        chk("post rst rd", rd_addr_o, 7);
        chk("post rst pc", pc_o, 32'h11C);

        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
